// File: rtl/db15_joy_reader.sv
// DB15 two-player joystick reader for a 74HC165-style shift chain.
// Ports: clk_sys/RESET; joy_data in; joy_clk/joy_load out;
//   joystick1/joystick2 debounced buttons; upd, frame_tick pulses.
module db15_joy_reader #(
  parameter int CLK_DIV         = 8,
  parameter int BITS_PER_PLAYER = 12,
  parameter int FRAME_GAP       = 1024
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        upd,
  output logic        frame_tick
);

  localparam int         FW     = 2 * BITS_PER_PLAYER;
  localparam int         B      = BITS_PER_PLAYER;
  localparam logic [4:0] K_LAST = 5'(FW - 1);

  typedef enum logic [2:0] {
    S_GAP, S_LOAD, S_LOW, S_HIGH, S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [8:0]      div_cnt;
  logic [15:0]     gap_cnt;
  logic [4:0]      k;
  logic [FW-1:0]   sh;
  logic [FW-1:0]   prev_frame;
  logic [15:0]     j1_new;
  logic [15:0]     j2_new;
  logic            ph_end;
  logic            load_end;
  logic            gap_end;

  assign ph_end   = (div_cnt == 9'(CLK_DIV - 1));
  assign load_end = (div_cnt == 9'(2 * CLK_DIV - 1));
  assign gap_end  = (gap_cnt == 16'(FRAME_GAP - 1));

  always_ff @(posedge clk_sys) begin
    if (RESET) state <= S_GAP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_GAP:  if (gap_end) state_nxt = S_LOAD;
      S_LOAD: if (load_end) state_nxt = S_LOW;
      S_LOW:
        if (ph_end)
          state_nxt = (k == K_LAST) ? S_DONE : S_HIGH;
      S_HIGH: if (ph_end) state_nxt = S_LOW;
      S_DONE: state_nxt = S_GAP;
      default: state_nxt = S_GAP;
    endcase
  end

  always_comb begin
    joy_clk  = (state == S_HIGH);
    joy_load = (state != S_LOAD);
  end

  // Raw samples are active-low; outputs are active-high.
  always_comb begin
    j1_new = '0;
    j2_new = '0;
    j1_new[B-1:0] = ~sh[B-1:0];
    j2_new[B-1:0] = ~sh[FW-1:B];
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      div_cnt    <= '0;
      gap_cnt    <= '0;
      k          <= '0;
      sh         <= '0;
      prev_frame <= '1;
      joystick1  <= '0;
      joystick2  <= '0;
      upd        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      upd        <= 1'b0;
      frame_tick <= 1'b0;
      // Divider restarts on every state entry.
      if (state_nxt != state || state == S_GAP) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + 9'd1;
      if (state == S_GAP && state_nxt == S_GAP) gap_cnt <= gap_cnt + 16'd1;
      else                                      gap_cnt <= '0;
      if (state == S_LOAD)                k <= '0;
      else if (state == S_HIGH && ph_end) k <= k + 5'd1;
      if (state == S_LOW && ph_end) begin
        for (int i = 0; i < FW; i++)
          if (k == 5'(i)) sh[i] <= joy_data;
      end
      // Commit only when two consecutive frames agree.
      if (state == S_DONE) begin
        frame_tick <= 1'b1;
        prev_frame <= sh;
        if (sh == prev_frame) begin
          joystick1 <= j1_new;
          joystick2 <= j2_new;
          upd <= (j1_new != joystick1) || (j2_new != joystick2);
        end
      end
    end
  end

endmodule

// File: tb/tb_db15_joy_reader.sv
// Testbench for db15_joy_reader with a 74HC165 adapter model.
// Default instance plus a small CLK_DIV=2/8-bit/GAP=4 instance.
module tb_db15_joy_reader;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        upd;
  logic        frame_tick;

  logic        d2_data = 1'b0;
  logic        d2_clk;
  logic        d2_load;
  logic [15:0] d2_j1;
  logic [15:0] d2_j2;
  logic        d2_upd;
  logic        d2_tick;

  logic [11:0] p1 = '0;
  logic [11:0] p2 = '0;
  logic [23:0] sr = '1;
  logic        jc_q = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  db15_joy_reader dut (
    .clk_sys(clk_sys), .RESET(RESET), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load),
    .joystick1(joystick1), .joystick2(joystick2),
    .upd(upd), .frame_tick(frame_tick)
  );

  db15_joy_reader #(
    .CLK_DIV(2), .BITS_PER_PLAYER(8), .FRAME_GAP(4)
  ) dut2 (
    .clk_sys(clk_sys), .RESET(RESET), .joy_data(d2_data),
    .joy_clk(d2_clk), .joy_load(d2_load),
    .joystick1(d2_j1), .joystick2(d2_j2),
    .upd(d2_upd), .frame_tick(d2_tick)
  );

  // Adapter: parallel load while joy_load low, shift on joy_clk rise.
  always @(posedge clk_sys) begin
    jc_q <= joy_clk;
    if (!joy_load)            sr <= ~{p2, p1};
    else if (joy_clk && !jc_q) sr <= {1'b1, sr[23:1]};
  end
  assign joy_data = sr[0];

  typedef struct {
    logic [11:0] p1;
    logic [11:0] p2;
    logic [15:0] j1;
    logic [15:0] j2;
    int          u;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_tick(output int n, output int u);
    n = 0;
    u = 0;
    do begin
      @(negedge clk_sys);
      n++;
      if (upd) u++;
    end while (!frame_tick && n < 3000);
    chk("tick_seen", int'(frame_tick), 1);
  endtask

  task automatic wait_load_fall(output int n, output int t);
    n = 0;
    t = 0;
    do begin
      @(negedge clk_sys);
      n++;
      if (frame_tick || upd) t++;
    end while (joy_load && n < 3000);
    chk("load_seen", int'(joy_load), 0);
  endtask

  // Scan one frame from the end of LOAD to frame_tick.
  task automatic scan_frame(output int rises, output int bad,
                            output int u);
    int run;
    int n;
    logic prev;
    rises = 0;
    bad = 0;
    u = 0;
    run = 0;
    n = 0;
    prev = 1'b0;
    do begin
      @(negedge clk_sys);
      n++;
      if (upd) u++;
      if (joy_clk) begin
        run++;
        if (!prev) rises++;
      end else if (prev) begin
        if (run != 8) bad++;
        run = 0;
      end
      prev = joy_clk;
    end while (!frame_tick && n < 3000);
    chk("scan_tick", int'(frame_tick), 1);
  endtask

  initial begin
    int n, u, m, t, r, bad, falls;
    logic prev;

    tbl[0]  = '{12'h000, 12'h000, 16'h0000, 16'h0000, 0};
    tbl[1]  = '{12'h001, 12'h800, 16'h0000, 16'h0000, 0};
    tbl[2]  = '{12'h001, 12'h800, 16'h0001, 16'h0800, 1};
    tbl[3]  = '{12'h001, 12'h800, 16'h0001, 16'h0800, 0};
    tbl[4]  = '{12'h000, 12'h000, 16'h0001, 16'h0800, 0};
    tbl[5]  = '{12'h000, 12'h000, 16'h0000, 16'h0000, 1};
    tbl[6]  = '{12'h010, 12'h000, 16'h0000, 16'h0000, 0};
    tbl[7]  = '{12'h000, 12'h000, 16'h0000, 16'h0000, 0};
    tbl[8]  = '{12'h000, 12'h000, 16'h0000, 16'h0000, 0};
    tbl[9]  = '{12'hFFF, 12'hFFF, 16'h0000, 16'h0000, 0};
    tbl[10] = '{12'hFFF, 12'hFFF, 16'h0FFF, 16'h0FFF, 1};
    tbl[11] = '{12'h000, 12'h000, 16'h0FFF, 16'h0FFF, 0};
    tbl[12] = '{12'h000, 12'h000, 16'h0000, 16'h0000, 1};

    repeat (3) @(negedge clk_sys);
    chk("rst_load", int'(joy_load), 1);
    chk("rst_clk", int'(joy_clk), 0);
    chk("rst_j1", int'(joystick1), 0);
    chk("rst_tick", int'(frame_tick), 0);
    RESET = 1'b0;

    // Idle adapter: frame timing.
    wait_load_fall(n, t);
    chk("load_fall", n, 1024);
    chk("early_pulse", t, 0);
    m = 0;
    while (!joy_load && m < 100) begin
      m++;
      @(negedge clk_sys);
    end
    chk("load_len", m, 16);
    scan_frame(r, bad, u);
    chk("clk_rises", r, 23);
    chk("clk_high_len", bad, 0);
    chk("idle_upd", u, 0);
    chk("idle_j1", int'(joystick1), 0);
    wait_tick(n, u);
    chk("frame_len", n, 1417);
    chk("idle_upd2", u, 0);
    chk("idle_j2", int'(joystick2), 0);

    // Debounce table, one frame per vector.
    for (int i = 0; i < 13; i++) begin
      p1 = tbl[i].p1;
      p2 = tbl[i].p2;
      wait_tick(n, u);
      chk($sformatf("v%0d_j1", i), int'(joystick1), int'(tbl[i].j1));
      chk($sformatf("v%0d_j2", i), int'(joystick2), int'(tbl[i].j2));
      chk($sformatf("v%0d_upd", i), u, tbl[i].u);
    end

    // Stuck-0 line, then reset in LOW at k=10.
    p1 = 12'hFFF;
    p2 = 12'hFFF;
    wait_tick(n, u);
    wait_tick(n, u);
    chk("stuck0_j1", int'(joystick1), 16'h0FFF);
    wait_load_fall(n, t);
    falls = 0;
    prev = 1'b0;
    n = 0;
    while (falls < 10 && n < 3000) begin
      @(negedge clk_sys);
      n++;
      if (prev && !joy_clk) falls++;
      prev = joy_clk;
    end
    chk("k10_reached", falls, 10);
    repeat (3) @(negedge clk_sys);
    RESET = 1'b1;
    @(negedge clk_sys);
    chk("mid_clk", int'(joy_clk), 0);
    chk("mid_load", int'(joy_load), 1);
    chk("mid_j1", int'(joystick1), 0);
    chk("mid_j2", int'(joystick2), 0);
    chk("mid_upd", int'(upd), 0);
    chk("mid_tick", int'(frame_tick), 0);
    repeat (4) @(negedge clk_sys);
    RESET = 1'b0;
    wait_load_fall(n, t);
    chk("re_load_fall", n, 1024);
    chk("re_early_pulse", t, 0);
    scan_frame(r, bad, u);
    chk("re_rises", r, 23);
    chk("re_j1_first", int'(joystick1), 0);
    wait_tick(n, u);
    chk("re_j1", int'(joystick1), 16'h0FFF);
    chk("re_j2", int'(joystick2), 16'h0FFF);
    chk("re_upd", u, 1);

    // Small instance: all data low.
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!d2_tick && n < 500);
    chk("d2_tick_seen", int'(d2_tick), 1);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!d2_tick && n < 500);
    chk("d2_frame_len", n, 71);
    chk("d2_j1", int'(d2_j1), 16'h00FF);
    chk("d2_j2", int'(d2_j2), 16'h00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
